// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-channel programmable clock divider with per-channel load handshake.
// Optional macro CLKDIV_DUTY50_EN adds a negedge flop per channel for 50% duty on odd divisors.
`default_nettype none

module clk_div_gen #(
  parameter int CH      = 2,
  parameter int W       = 8,
  parameter int DIV_RST = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH-1:0]     en_i,
  input  logic [CH*W-1:0]   div_i,
  input  logic [CH-1:0]     load_i,
  output logic [CH-1:0]     load_ack_o,
  output logic [CH-1:0]     clk_o,
  output logic [CH-1:0]     tick_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [W-1:0] C_DIV_MIN = W'(2);
  localparam logic [W-1:0] C_DIV_RST = W'(DIV_RST);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    state_t       r_state;
    logic [W-1:0] r_div_q;
    logic [W-1:0] r_cnt;
    logic         r_clk_pos;
    logic         r_tick;
    logic         r_ack;

    logic [W-1:0] w_div_req;
    logic [W-1:0] w_div_cl;
    logic [W-1:0] w_cnt_nxt;
    logic [W-1:0] w_half;
    logic         w_term;

    assign w_div_req = div_i[c*W +: W];
    assign w_div_cl  = (w_div_req < C_DIV_MIN) ? C_DIV_MIN : w_div_req;
    assign w_cnt_nxt = r_cnt + W'(1);
    assign w_half    = r_div_q >> 1;
    assign w_term    = (r_cnt == (r_div_q - W'(1)));

    // Divisor and run state only change at period boundaries, so clk_o never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state   <= ST_IDLE;
        r_div_q   <= C_DIV_RST;
        r_cnt     <= '0;
        r_clk_pos <= 1'b0;
        r_tick    <= 1'b0;
        r_ack     <= 1'b0;
      end else begin
        r_tick <= 1'b0;
        r_ack  <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            r_cnt     <= '0;
            r_clk_pos <= 1'b0;
            if (load_i[c]) begin
              r_div_q <= w_div_cl;
              r_ack   <= 1'b1;
            end
            if (en_i[c]) begin
              r_state   <= ST_RUN;
              r_clk_pos <= 1'b1;
              r_tick    <= 1'b1;
            end
          end
          default: begin
            if (w_term) begin
              r_cnt <= '0;
              if (load_i[c]) begin
                r_div_q <= w_div_cl;
                r_ack   <= 1'b1;
              end
              if (en_i[c]) begin
                r_clk_pos <= 1'b1;
                r_tick    <= 1'b1;
              end else begin
                r_state   <= ST_IDLE;
                r_clk_pos <= 1'b0;
              end
            end else begin
              r_cnt     <= w_cnt_nxt;
              r_clk_pos <= (w_cnt_nxt < w_half);
            end
          end
        endcase
      end
    end

    assign tick_o[c]     = r_tick;
    assign load_ack_o[c] = r_ack;

`ifdef CLKDIV_DUTY50_EN
    logic r_clk_neg;

    // Half-cycle-delayed copy stretches the high phase by 0.5 cycle for odd divisors.
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_clk_neg <= 1'b0;
      end else begin
        r_clk_neg <= r_clk_pos;
      end
    end

    assign clk_o[c] = r_clk_pos | (r_div_q[0] & r_clk_neg);
`else
    assign clk_o[c] = r_clk_pos;
`endif
  end

endmodule

`default_nettype wire
